pkt_egress_arbiter: RTL

- Round-robin scheduler sharing one egress byte stream (toward the TX MAC) among pPORTS ingress packet buffers.
- Each buffer exposes a "packet ready" flag, the head packet length from its length FIFO, and a 1-cycle-latency SRAM read port.
- The arbiter picks a source, pops its length and strobes its read enable for exactly len bytes.
- It forwards the bytes as a contiguous otx_en frame, then enforces the inter-frame gap.

---
 rtl/pkt_sched_pkg.sv | 18 +
 rtl/pkt_egress_arbiter_rr_arbiter.sv | 33 +++
 rtl/pkt_egress_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pkt_sched_pkg.sv
// Shared types and constants for the egress packet scheduler.
// The preamble constants are only consumed when PREAMBLE_GEN_EN is defined.
package pkt_sched_pkg;

  // Scheduler states; lpS_PRE is only reachable with PREAMBLE_GEN_EN defined
  typedef enum logic [2:0] {
    lpS_IDLE,
    lpS_LOAD,
    lpS_PRE,
    lpS_SEND,
    lpS_IFG
  } state_t;

  localparam logic [7:0] lpPREAMBLE     = 8'h55;
  localparam logic [7:0] lpSFD_BYTE     = 8'hD5;
  localparam int         lpPREAMBLE_LEN = 8;

endpackage

// File: rtl/pkt_egress_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter.
// The search starts at the port just after ilast and wraps around, so the
// most recently served port has the lowest priority.
module rr_arbiter #(
  parameter  int pPORTS  = 4,
  localparam int lpIDX_W = $clog2(pPORTS)
) (
  input  logic [pPORTS-1:0]  ireq,
  input  logic [lpIDX_W-1:0] ilast,
  output logic [pPORTS-1:0]  ogrant,
  output logic [lpIDX_W-1:0] oidx
);

  logic               found;
  logic [lpIDX_W-1:0] cand;

  // Walk the ports in priority order and keep the first requester found
  always_comb begin
    ogrant = '0;
    oidx   = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= pPORTS; k++) begin
      cand = lpIDX_W'((int'(ilast) + k) % pPORTS);
      if (!found && ireq[cand]) begin
        found        = 1'b1;
        ogrant[cand] = 1'b1;
        oidx         = cand;
      end
    end
  end

endmodule

// File: rtl/pkt_egress_arbiter.sv
// Round-robin egress scheduler: picks one ingress packet buffer at a time,
// pops its head length, reads exactly that many bytes from its SRAM and
// forwards them as one contiguous otx_en frame followed by an inter-frame gap.
// Optional feature macro: PREAMBLE_GEN_EN (prepends 7x 0x55 + 0xD5 to each frame).
module pkt_egress_arbiter
  import pkt_sched_pkg::*;
#(
  parameter int pPORTS      = 4,
  parameter int pDATA_WIDTH = 8,
  parameter int pLEN_WIDTH  = 11,
  parameter int pIFG_CYCLES = 12
) (
  input  logic                          iclk,
  input  logic                          i_rst,
  input  logic [pPORTS-1:0]             ireq,
  input  logic [pPORTS*pLEN_WIDTH-1:0]  ilen,
  input  logic [pPORTS*pDATA_WIDTH-1:0] idata,
  input  logic                          ipause,
  output logic [pPORTS-1:0]             olen_pop,
  output logic [pPORTS-1:0]             ord_en,
  output logic [pPORTS-1:0]             ogrant,
  output logic                          otx_en,
  output logic [pDATA_WIDTH-1:0]        otx_d,
  output logic                          obusy
);

  localparam int lpIDX_W = $clog2(pPORTS);
  localparam int lpGAP_W = $clog2(pIFG_CYCLES + 1);

  state_t                  state;
  logic [lpIDX_W-1:0]      rsel;
  logic [lpIDX_W-1:0]      last;
  logic [pLEN_WIDTH-1:0]   rlen;
  logic [pLEN_WIDTH-1:0]   cnt;
  logic [lpGAP_W-1:0]      gap;

  logic [pPORTS-1:0]       arb_grant;
  logic [lpIDX_W-1:0]      arb_idx;

  logic                    valid_d1;
  logic [lpIDX_W-1:0]      sel_d1;

`ifdef PREAMBLE_GEN_EN
  logic [2:0]              pre_cnt;
  logic                    pre_d1;
  logic [pDATA_WIDTH-1:0]  pre_byte_d1;
`endif

  rr_arbiter #(
    .pPORTS (pPORTS)
  ) u_rr_arbiter (
    .ireq   (ireq),
    .ilast  (last),
    .ogrant (arb_grant),
    .oidx   (arb_idx)
  );

  // Scheduler FSM; all control outputs are registered alongside the state
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      state    <= lpS_IDLE;
      rsel     <= '0;
      last     <= lpIDX_W'(pPORTS - 1);
      rlen     <= '0;
      cnt      <= '0;
      gap      <= '0;
      olen_pop <= '0;
      ord_en   <= '0;
      ogrant   <= '0;
      obusy    <= 1'b0;
`ifdef PREAMBLE_GEN_EN
      pre_cnt  <= '0;
`endif
    end else begin
      olen_pop <= '0;
      case (state)
        lpS_IDLE: begin
          if (!ipause && (|ireq)) begin
            rsel     <= arb_idx;
            rlen     <= ilen[arb_idx*pLEN_WIDTH +: pLEN_WIDTH];
            olen_pop <= arb_grant;
            ogrant   <= arb_grant;
            obusy    <= 1'b1;
            state    <= lpS_LOAD;
          end
        end

        lpS_LOAD: begin
          last <= rsel;
          cnt  <= rlen;
          if (rlen == '0) begin
            ogrant <= '0;
            obusy  <= 1'b0;
            state  <= lpS_IDLE;
          end else begin
`ifdef PREAMBLE_GEN_EN
            pre_cnt <= '0;
            state   <= lpS_PRE;
`else
            ord_en  <= ogrant;
            state   <= lpS_SEND;
`endif
          end
        end

`ifdef PREAMBLE_GEN_EN
        lpS_PRE: begin
          pre_cnt <= pre_cnt + 3'd1;
          if (pre_cnt == 3'(lpPREAMBLE_LEN - 1)) begin
            ord_en <= ogrant;
            state  <= lpS_SEND;
          end
        end
`endif

        lpS_SEND: begin
          cnt <= cnt - pLEN_WIDTH'(1);
          if (cnt == pLEN_WIDTH'(1)) begin
            ord_en <= '0;
            gap    <= lpGAP_W'(pIFG_CYCLES - 1);
            state  <= lpS_IFG;
          end
        end

        lpS_IFG: begin
          if (gap == '0) begin
            ogrant <= '0;
            obusy  <= 1'b0;
            state  <= lpS_IDLE;
          end else begin
            gap <= gap - lpGAP_W'(1);
          end
        end

        default: begin
          ord_en <= '0;
          ogrant <= '0;
          obusy  <= 1'b0;
          state  <= lpS_IDLE;
        end
      endcase
    end
  end

  // Two-stage egress pipeline that absorbs the SRAM's one-cycle read latency
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      valid_d1    <= 1'b0;
      sel_d1      <= '0;
      otx_en      <= 1'b0;
      otx_d       <= '0;
`ifdef PREAMBLE_GEN_EN
      pre_d1      <= 1'b0;
      pre_byte_d1 <= '0;
`endif
    end else begin
      sel_d1 <= rsel;
      otx_en <= valid_d1;
`ifdef PREAMBLE_GEN_EN
      valid_d1    <= (|ord_en) || (state == lpS_PRE);
      pre_d1      <= (state == lpS_PRE);
      pre_byte_d1 <= (pre_cnt == 3'(lpPREAMBLE_LEN - 1)) ?
                     pDATA_WIDTH'(lpSFD_BYTE) : pDATA_WIDTH'(lpPREAMBLE);
      if (!valid_d1)
        otx_d <= '0;
      else if (pre_d1)
        otx_d <= pre_byte_d1;
      else
        otx_d <= idata[sel_d1*pDATA_WIDTH +: pDATA_WIDTH];
`else
      valid_d1 <= |ord_en;
      otx_d    <= valid_d1 ? idata[sel_d1*pDATA_WIDTH +: pDATA_WIDTH] : '0;
`endif
    end
  end

endmodule
